// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller.
//   fetch_state_e : controller state (IDLE, RUN)
//   fetch_entry_t : one buffered fetch result, {pc, instr}
//   PC_STEP       : byte distance between consecutive instruction words
package fetch_pkg;

   localparam int FETCH_AW = 32;
   localparam int FETCH_DW = 32;
   localparam int PC_STEP  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_AW-1:0] pc;
      logic [FETCH_DW-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between instruction fetch and decode.
// Ports:
//   clk, rst        clock, async active-high reset
//   push_i, din_i   enqueue din_i (ignored when full unless popping this cycle)
//   pop_i           dequeue head (ignored when empty)
//   flush_i         discard all entries; dominates push/pop
//   head_o          entry at the head (valid when !empty_o)
//   full_o, empty_o occupancy flags
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t din_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]  wr_q;
   logic [PW:0]  rd_q;
   fetch_entry_t mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = ((wr_q ^ rd_q) == {1'b1, {PW{1'b0}}});
   assign head_o  = mem_q[rd_q[PW-1:0]];

   assign do_pop  = pop_i && !flush_i && !empty_o;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (PW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
   end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the combinational
// instruction memory, and buffers {pc, instr} pairs for decode with a
// valid/ready handshake. A redirect flushes buffered work and restarts at the
// new PC.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start                    leave IDLE and begin fetching
//   imem_addr / imem_instr   byte address out (= pc), read data in
//   redirect_valid/_pc       load new PC (low two bits forced 0), flush queue
//   if_valid/if_ready        decode handshake; if_pc/if_instr = queue head
//   fetch_fault              sticky out-of-range fetch flag
// Build option FETCH_BOUNDS_CHECK_EN: stop fetching and raise fetch_fault when
// the PC word index reaches MEM_SIZE. Without it fetch_fault is 0 and addresses
// simply alias in memory.
//
// state | meaning
// IDLE  | after reset; redirect only loads pc, nothing is fetched
// RUN   | fetch one word per cycle while the queue has room (terminal)
module inst_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                   ADDRESS_WIDTH = 32,
   parameter int                   DATA_WIDTH    = 32,
   parameter int                   MEM_SIZE      = 256,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = '0,
   parameter int                   QUEUE_DEPTH   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_instr,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [ADDRESS_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0]    if_instr,
   output logic                     fetch_fault
);

   fetch_state_e             state_q;
   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [ADDRESS_WIDTH-1:0] hold_pc_q;
   logic [DATA_WIDTH-1:0]    hold_instr_q;

   fetch_entry_t             head;
   fetch_entry_t             din;
   logic                     full;
   logic                     empty;
   logic                     push;
   logic                     pop;
   logic                     in_range;
   logic                     run;
   logic                     unused_cfg;

   assign run       = (state_q == RUN);
   assign imem_addr = pc_q;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [ADDRESS_WIDTH-3:0] MEM_WORDS = (ADDRESS_WIDTH-2)'(MEM_SIZE);
   logic fault_q;

   assign in_range    = (pc_q[ADDRESS_WIDTH-1:2] < MEM_WORDS);
   assign fetch_fault = fault_q;
   assign unused_cfg  = ^redirect_pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (redirect_valid) begin
         fault_q <= 1'b0;
      end else if (run && !in_range) begin
         fault_q <= 1'b1;
      end
   end
`else
   assign in_range    = 1'b1;
   assign fetch_fault = 1'b0;
   assign unused_cfg  = (^redirect_pc[1:0]) ^ (MEM_SIZE == 0);
`endif

   // A pop in a redirect cycle is void: the entry is flushed, not consumed.
   assign pop  = !empty && if_ready && !redirect_valid;
   assign push = run && !redirect_valid && in_range && (!full || pop);

   assign din.pc    = FETCH_AW'(pc_q);
   assign din.instr = FETCH_DW'(imem_instr);

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .din_i   (din),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // While the queue is empty the outputs keep showing the last head.
   assign if_valid = !empty;
   assign if_pc    = empty ? hold_pc_q    : ADDRESS_WIDTH'(head.pc);
   assign if_instr = empty ? hold_instr_q : DATA_WIDTH'(head.instr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
         hold_pc_q    <= '0;
         hold_instr_q <= '0;
      end else begin
         case (state_q)
            IDLE:    if (start) state_q <= RUN;
            RUN:     state_q <= RUN;
            default: state_q <= IDLE;
         endcase

         if (redirect_valid) begin
            pc_q <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
         end else if (push) begin
            pc_q <= pc_q + ADDRESS_WIDTH'(PC_STEP);
         end

         if (!empty) begin
            hold_pc_q    <= ADDRESS_WIDTH'(head.pc);
            hold_instr_q <= DATA_WIDTH'(head.instr);
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

   localparam int          DEPTH    = 2;
   localparam int          MEM_SIZE = 256;
   localparam logic [31:0] RST_PC   = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        fetch_fault;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 + ((a >> 2) % MEM_SIZE);
   endfunction

   assign imem_instr = mem_word(imem_addr);

   inst_fetch_ctrl #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .MEM_SIZE      (MEM_SIZE),
      .RESET_PC      (RST_PC),
      .QUEUE_DEPTH   (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .fetch_fault    (fetch_fault)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] addr;
      logic        fault;
   } exp_t;

   exp_t cyc_q[$];
   ent_t dlv_q[$];

   // Reference model: a plain list of fetched-but-unconsumed words.
   ent_t        mq[$];
   logic [31:0] mpc;
   bit          mrun;
   bit          mfault;
   ent_t        mlast;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
`ifdef FETCH_BOUNDS_CHECK_EN
      return (a >> 2) < MEM_SIZE;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      mpc    = RST_PC & ~32'h3;
      mrun   = 1'b0;
      mfault = 1'b0;
      mlast  = '0;
   endtask

   task automatic model_advance(input bit s, input bit rv, input logic [31:0] rp, input bit rdy);
      bit   was_run = mrun;
      bit   ok;
      ent_t e;
      if (mq.size() > 0) mlast = mq[0];
      if (!mrun && s) mrun = 1'b1;
      if (rv) begin
         mq.delete();
         mpc    = rp & ~32'h3;
         mfault = 1'b0;
      end else if (was_run) begin
         ok = addr_ok(mpc);
         if (!ok) mfault = 1'b1;
         if (mq.size() > 0 && rdy) dlv_q.push_back(mq.pop_front());
         if (ok && mq.size() < DEPTH) begin
            e.pc    = mpc;
            e.instr = mem_word(mpc);
            mq.push_back(e);
            mpc = mpc + 32'd4;
         end
      end
   endtask

   task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rp, input bit rdy);
      exp_t e;
      @(negedge clk);
      rst            = r;
      start          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
      if_ready       = rdy;
      if (r) model_reset();
      e.valid = (mq.size() > 0);
      e.pc    = e.valid ? mq[0].pc    : mlast.pc;
      e.instr = e.valid ? mq[0].instr : mlast.instr;
      e.addr  = mpc;
`ifdef FETCH_BOUNDS_CHECK_EN
      e.fault = mfault;
`else
      e.fault = 1'b0;
`endif
      cyc_q.push_back(e);
      if (!r) model_advance(s, rv, rp, rdy);
   endtask

   task automatic run_ready(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, rdy);
   endtask

   // Monitor: compares the presented outputs each cycle and every accepted
   // entry against the scoreboard, independent of the stimulus process.
   initial begin
      exp_t e;
      ent_t d;
      forever begin
         @(negedge clk);
         #3;
         if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
            chk("if_pc", if_pc, e.pc);
            chk("if_instr", if_instr, e.instr);
            chk("imem_addr", imem_addr, e.addr);
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
         end
         if (!rst && if_valid && if_ready && !redirect_valid) begin
            if (dlv_q.size() == 0) begin
               chk("unexpected_accept", if_pc, 32'hFFFF_FFFF);
            end else begin
               d = dlv_q.pop_front();
               chk("accept_pc", if_pc, d.pc);
               chk("accept_instr", if_instr, d.instr);
            end
         end
      end
   end

   initial begin
      logic [31:0] rp;
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
      model_reset();

      step(1, 0, 0, 32'h0, 1);
      step(1, 0, 0, 32'h0, 1);
      run_ready(2, 1);                    // idle without start: nothing fetched
      step(0, 1, 0, 32'h0, 1);
      run_ready(10, 1);                   // 1 instr/cycle stream
      run_ready(5, 0);                    // back-pressure, queue fills
      run_ready(3, 1);
      run_ready(3, 0);
      step(0, 0, 1, 32'h103, 0);          // redirect while full
      run_ready(4, 1);
      step(0, 0, 1, 32'h20, 1);           // redirect with concurrent ready
      run_ready(4, 1);
      step(1, 0, 0, 32'h0, 1);            // reset mid-stream
      run_ready(3, 1);
      step(0, 0, 1, 32'h40, 1);           // redirect in IDLE loads pc only
      run_ready(2, 1);
      step(0, 1, 0, 32'h0, 1);
      run_ready(4, 1);
      step(0, 0, 1, 32'h3FC, 1);          // top of memory
      run_ready(6, 1);
      step(0, 0, 1, 32'h0, 1);
      run_ready(4, 1);
      step(0, 0, 1, 32'hFFFF_FFF8, 1);    // pc wrap
      run_ready(5, 1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) rp = 32'h3F0 + $urandom_range(0, 15);
         else                           rp = $urandom & 32'h7FF;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0, rp, $urandom_range(0, 3) != 0);
      end

      run_ready(3, 0);
      @(negedge clk);
      #5;
      chk("pending_cycles", cyc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
